// File: rtl/edge_stream_pkg.sv
// edge_stream_pkg: shared constants for the streaming gradient-magnitude engine.
//   WORD_SIZE / MAX   : default pixel width and its largest value
//   kernel_e          : run-time kernel select encoding
//   SOBEL_* / SCHARR_*: (a,b,a) coefficient pairs for each kernel
package edge_stream_pkg;

  localparam int WORD_SIZE = 8;
  localparam int MAX       = (1 << WORD_SIZE) - 1;

  typedef enum logic {
    KERNEL_SOBEL  = 1'b0,
    KERNEL_SCHARR = 1'b1
  } kernel_e;

  localparam int SOBEL_A  = 1;
  localparam int SOBEL_B  = 2;
  localparam int SCHARR_A = 3;
  localparam int SCHARR_B = 10;

endpackage

// File: rtl/edge_stream_if.sv
// edge_stream_if: pixel-in / result-out bundle of edge_stream.
//   in_valid, in_sof, in_pixel, kernel_sel : upstream pixel stream
//   threshold                              : edge threshold for the output stage
//   out_valid, out_mag, out_edge, out_last : result stream
// master = producer/consumer around the engine, slave = the engine itself.
interface edge_stream_if
  import edge_stream_pkg::*;
#(
  parameter int WORD_SIZE = edge_stream_pkg::WORD_SIZE
) ();

  logic                 in_valid;
  logic                 in_sof;
  logic [WORD_SIZE-1:0] in_pixel;
  logic                 kernel_sel;
  logic [WORD_SIZE-1:0] threshold;

  logic                 out_valid;
  logic [WORD_SIZE-1:0] out_mag;
  logic                 out_edge;
  logic                 out_last;

  modport master (
    output in_valid, in_sof, in_pixel, kernel_sel, threshold,
    input  out_valid, out_mag, out_edge, out_last
  );

  modport slave (
    input  in_valid, in_sof, in_pixel, kernel_sel, threshold,
    output out_valid, out_mag, out_edge, out_last
  );

endinterface

// File: rtl/edge_stream_line_buffer.sv
// line_buffer: single-port read-before-write row store.
//   clk     : clock
//   en      : write enable (one write per accepted pixel)
//   addr    : column address, shared by read and write
//   wr_data : value stored at addr on an enabled edge
//   rd_data : current content of addr (combinational, i.e. the old value
//             during the cycle in which it is being overwritten)
// Contents are deliberately not reset.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[addr];

  always_ff @(posedge clk) begin
    if (en) mem_q[addr] <= wr_data;
  end

endmodule

// File: rtl/edge_stream.sv
// edge_stream: raster-order 3x3 gradient magnitude, |dx|+|dy| saturated,
// with a thresholded edge bit and end-of-frame flag.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   en       : global enable, low freezes every register
//   bus      : edge_stream_if.slave (pixel stream in, result stream out)
// Pipeline: S0 counters/line buffers/window, S1 dx/dy, S2 magnitude/outputs.
module edge_stream #(
  parameter int WORD_SIZE  = edge_stream_pkg::WORD_SIZE,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  edge_stream_if.slave  bus
);
  import edge_stream_pkg::*;

  localparam int CW   = $clog2(IMG_WIDTH);
  localparam int RW   = $clog2(IMG_HEIGHT);
  localparam int DW   = WORD_SIZE + 5;
  localparam int SW   = WORD_SIZE + 6;
  localparam int MAXW = (1 << WORD_SIZE) - 1;

  logic                 accept;
  logic [CW-1:0]        col_q, col_d, cur_col;
  logic [RW-1:0]        row_q, row_d, cur_row;
  logic [WORD_SIZE-1:0] lb0_rd, lb1_rd;

  // win_q[0..8] = p1..p9; p1..p3 oldest row, left to right
  logic [WORD_SIZE-1:0] win_q [9];
  logic                 valid0_q, last0_q, ksel0_q;

  logic signed [DW-1:0] coef_a, coef_b, dx_d, dy_d, dx_q, dy_q;
  logic                 valid1_q, last1_q;

  logic [SW-1:0]        sum_w;
  logic [WORD_SIZE-1:0] mag_d;
  logic                 edge_d;
  logic                 out_valid_q, out_last_q, out_edge_q;
  logic [WORD_SIZE-1:0] out_mag_q;

  assign accept = en & bus.in_valid;

  // in_sof overrides the counters so this pixel is (0,0)
  assign cur_col = bus.in_sof ? '0 : col_q;
  assign cur_row = bus.in_sof ? '0 : row_q;

  always_comb begin
    col_d = cur_col + CW'(1);
    row_d = cur_row;
    if (cur_col == CW'(IMG_WIDTH - 1)) begin
      col_d = '0;
      row_d = (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
    end
  end

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(WORD_SIZE), .AW(CW)) u_line0 (
    .clk     (clk),
    .en      (accept),
    .addr    (cur_col),
    .wr_data (bus.in_pixel),
    .rd_data (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(WORD_SIZE), .AW(CW)) u_line1 (
    .clk     (clk),
    .en      (accept),
    .addr    (cur_col),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  function automatic logic signed [DW-1:0] sx(input logic [WORD_SIZE-1:0] p);
    return $signed({5'b00000, p});
  endfunction

  function automatic logic [SW-1:0] abs_of(input logic signed [DW-1:0] v);
    logic [DW-1:0] m;
    m = v[DW-1] ? DW'(-v) : DW'(v);
    return {1'b0, m};
  endfunction

  // Coefficients follow the kernel flag captured with the newest pixel.
  always_comb begin
    coef_a = (ksel0_q == KERNEL_SCHARR) ? DW'(SCHARR_A) : DW'(SOBEL_A);
    coef_b = (ksel0_q == KERNEL_SCHARR) ? DW'(SCHARR_B) : DW'(SOBEL_B);
    dx_d = coef_a * (sx(win_q[0]) + sx(win_q[6]) - sx(win_q[2]) - sx(win_q[8]))
         + coef_b * (sx(win_q[3]) - sx(win_q[5]));
    dy_d = coef_a * (sx(win_q[0]) + sx(win_q[2]) - sx(win_q[6]) - sx(win_q[8]))
         + coef_b * (sx(win_q[1]) - sx(win_q[7]));
  end

  always_comb begin
    sum_w  = abs_of(dx_q) + abs_of(dy_q);
    mag_d  = (sum_w > SW'(MAXW)) ? '1 : sum_w[WORD_SIZE-1:0];
    edge_d = (mag_d > bus.threshold);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q       <= '0;
      row_q       <= '0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
      valid0_q    <= 1'b0;
      last0_q     <= 1'b0;
      ksel0_q     <= 1'b0;
      dx_q        <= '0;
      dy_q        <= '0;
      valid1_q    <= 1'b0;
      last1_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_edge_q  <= 1'b0;
      out_mag_q   <= '0;
    end else if (en) begin
      if (bus.in_valid) begin
        col_q    <= col_d;
        row_q    <= row_d;
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= lb1_rd;
        win_q[3] <= win_q[4];
        win_q[4] <= win_q[5];
        win_q[5] <= lb0_rd;
        win_q[6] <= win_q[7];
        win_q[7] <= win_q[8];
        win_q[8] <= bus.in_pixel;
        ksel0_q  <= bus.kernel_sel;
      end
      valid0_q    <= bus.in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      last0_q     <= bus.in_valid && (cur_row == RW'(IMG_HEIGHT - 1))
                                  && (cur_col == CW'(IMG_WIDTH - 1));
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      valid1_q    <= valid0_q;
      last1_q     <= last0_q;
      out_valid_q <= valid1_q;
      out_last_q  <= last1_q;
      out_mag_q   <= mag_d;
      out_edge_q  <= edge_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_mag   = out_mag_q;
  assign bus.out_edge  = out_edge_q;

endmodule

// File: tb/tb_edge_stream.sv
// tb_edge_stream: randomized stimulus for edge_stream (8x6 frames) checked
// against a frame-array model of the 3x3 gradient rules, plus literal
// expectations for the flat / step / saturation / restart scenarios.
module tb_edge_stream;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int WS = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic en;
  always #5 clk = ~clk;

  edge_stream_if #(.WORD_SIZE(WS)) bus ();

  edge_stream #(.WORD_SIZE(WS), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .bus     (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int idx;
    int mag;
    bit last;
    int cc;
  } exp_t;

  exp_t q[$];
  int   img [H][W];
  int   rand_img [H][W];
  int   mr = 0, mc = 0, e = 0;
  int   pin_mode = 0, res_cnt = 0, last_cnt = 0, last_at = 0;
  int   rec_sel = 0;
  int   rec_a[$], rec_b[$];
  int   hold_val = 0;

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  // Gradient of the window whose newest pixel is (r,c), straight from the formulas.
  function automatic int grad_mag(int r, int c, bit k);
    int a, b, dx, dy, s;
    a  = k ? 3 : 1;
    b  = k ? 10 : 2;
    dx = a*img[r-2][c-2] + b*img[r-1][c-2] + a*img[r][c-2]
       - (a*img[r-2][c] + b*img[r-1][c] + a*img[r][c]);
    dy = a*img[r-2][c-2] + b*img[r-2][c-1] + a*img[r-2][c]
       - (a*img[r][c-2] + b*img[r][c-1] + a*img[r][c]);
    s  = iabs(dx) + iabs(dy);
    return (s > 255) ? 255 : s;
  endfunction

  function automatic int pin_lit(int mode, int cc);
    case (mode)
      1:       return 0;
      2:       return (cc == 3 || cc == 4) ? 40 : 0;
      3:       return (cc == 3 || cc == 4) ? 160 : 0;
      default: return (cc == 3 || cc == 4) ? 255 : 0;
    endcase
  endfunction

  // Compare process: samples inputs at the edge, checks outputs 1 time unit later.
  initial begin
    logic rn, en_s, iv, sf, ks;
    int   px, lit;
    bit   exp_v;
    exp_t ex;
    forever begin
      @(posedge clk);
      rn = reset_n; en_s = en; iv = bus.in_valid; sf = bus.in_sof;
      px = int'(bus.in_pixel); ks = bus.kernel_sel;
      #1;
      if (!rn) begin
        q.delete();
        mr = 0; mc = 0;
        chk("reset_outputs", int'({bus.out_valid, bus.out_last, bus.out_edge, bus.out_mag}), 0);
      end else if (en_s) begin
        e++;
        if (iv) begin
          if (sf) begin mr = 0; mc = 0; end
          img[mr][mc] = px;
          if (mr >= 2 && mc >= 2) begin
            ex.idx  = e + 2;
            ex.mag  = grad_mag(mr, mc, ks);
            ex.last = (mr == H-1 && mc == W-1);
            ex.cc   = mc - 1;
            q.push_back(ex);
          end
          if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
          end else mc++;
        end
        exp_v = (q.size() > 0) && (q[0].idx == e);
        chk("out_valid", int'(bus.out_valid), int'(exp_v));
        if (exp_v) begin
          ex = q.pop_front();
          chk("out_mag", int'(bus.out_mag), ex.mag);
          chk("out_edge", int'(bus.out_edge), (ex.mag > int'(bus.threshold)) ? 1 : 0);
          chk("out_last", int'(bus.out_last), int'(ex.last));
          if (pin_mode != 0) begin
            lit = pin_lit(pin_mode, ex.cc);
            chk("pin_mag", int'(bus.out_mag), lit);
            if (pin_mode == 4)
              chk("pin_edge", int'(bus.out_edge), (lit > int'(bus.threshold)) ? 1 : 0);
          end
        end
        if (bus.out_valid) begin
          res_cnt++;
          if (bus.out_last) begin last_cnt++; last_at = res_cnt; end
          if (rec_sel == 1) rec_a.push_back(int'(bus.out_mag));
          if (rec_sel == 2) rec_b.push_back(int'(bus.out_mag));
        end
      end else begin
        chk("stall_hold", int'({bus.out_valid, bus.out_last, bus.out_edge, bus.out_mag}), hold_val);
      end
      hold_val = int'({bus.out_valid, bus.out_last, bus.out_edge, bus.out_mag});
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic idle(int n);
    en = 1'b1; bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_px(int p, bit sof, bit k, bit gaps);
    int n = 0;
    if (gaps) begin
      while (n < 4 && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          en = 1'b0; bus.in_valid = 1'($urandom_range(0, 1));
        end else begin
          en = 1'b1; bus.in_valid = 1'b0;
        end
        bus.in_sof   = 1'($urandom_range(0, 1));
        bus.in_pixel = 8'($urandom);
        @(negedge clk);
        n++;
      end
    end
    en = 1'b1; bus.in_valid = 1'b1; bus.in_sof = sof;
    bus.in_pixel = 8'(p); bus.kernel_sel = k;
    @(negedge clk);
  endtask

  function automatic int pix_of(int pat, int r, int c);
    case (pat)
      0:       return 77;
      1:       return (c >= 4) ? 10 : 0;
      2:       return (c >= 4) ? 100 : 0;
      default: return rand_img[r][c];
    endcase
  endfunction

  // k = 2 picks a random kernel for every pixel.
  task automatic send_pixels(int pat, int k, bit gaps, bit sof_first, int count);
    bit kk;
    for (int i = 0; i < count; i++) begin
      kk = (k == 2) ? 1'($urandom_range(0, 1)) : 1'(k);
      send_px(pix_of(pat, i / W, i % W), sof_first && i == 0, kk, gaps);
    end
  endtask

  task automatic scen_begin(int mode);
    res_cnt = 0; last_cnt = 0; last_at = 0; pin_mode = mode;
  endtask

  task automatic scen_end(string name, int exp_res);
    idle(6);
    chk({name, "_results"}, res_cnt, exp_res);
    chk({name, "_last_count"}, last_cnt, 1);
    chk({name, "_last_pos"}, last_at, exp_res);
    pin_mode = 0;
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_pixel = '0;
    bus.kernel_sel = 1'b0; bus.threshold = 8'd20;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) rand_img[r][c] = $urandom_range(0, 255);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    scen_begin(1); send_pixels(0, 0, 0, 1, W*H); scen_end("flat", 24);
    scen_begin(2); send_pixels(1, 0, 0, 1, W*H); scen_end("step_sobel", 24);
    scen_begin(3); send_pixels(1, 1, 0, 1, W*H); scen_end("step_scharr", 24);

    bus.threshold = 8'd254;
    scen_begin(4); send_pixels(2, 0, 0, 1, W*H); scen_end("sat_thr254", 24);
    bus.threshold = 8'd255;
    scen_begin(4); send_pixels(2, 0, 0, 1, W*H); scen_end("sat_thr255", 24);
    bus.threshold = 8'd60;

    rec_sel = 1;
    scen_begin(0); send_pixels(3, 0, 0, 1, W*H); scen_end("rand_nogap", 24);
    rec_sel = 2;
    scen_begin(0); send_pixels(3, 0, 1, 1, W*H); scen_end("rand_gaps", 24);
    rec_sel = 0;
    chk("gap_run_length", rec_b.size(), rec_a.size());
    for (int i = 0; i < rec_a.size() && i < rec_b.size(); i++)
      chk("gap_vs_nogap", rec_b[i], rec_a[i]);

    scen_begin(0); send_pixels(3, 2, 1, 1, W*H); scen_end("rand_kernel", 24);

    // reset pulse where pixel (3,5) would have been, then a frame with no in_sof
    send_pixels(3, 0, 0, 1, 3*W + 5);
    reset_n = 1'b0; en = 1'b1; bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    scen_begin(0); send_pixels(3, 0, 1, 0, W*H); scen_end("after_reset", 24);

    // in_sof at pixel (4,2): aborted frame still emits rows 2..3, then a full frame
    scen_begin(0);
    send_pixels(2, 0, 0, 1, 4*W + 2);
    send_pixels(3, 0, 0, 1, W*H);
    scen_end("sof_restart", 36);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
